// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared state encoding and counter sizing for handshake_arbiter
package handshake_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   // The abort counter only has to reach cycles-1, so clog2(cycles) bits are enough.
   function automatic int cnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr, wrapping NUM_CH-1 -> 0
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int IW     = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IW-1:0]     ptr,
   output logic              valid,
   output logic [IW-1:0]     index
);

   int          w_pos;
   logic [IW-1:0] w_idx;

   // Walk from the farthest offset back to ptr so the nearest requester wins last.
   always_comb begin
      valid = 1'b0;
      index = '0;
      w_pos = 0;
      w_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_pos = int'(ptr) + k;
         if (w_pos >= NUM_CH) begin
            w_pos = w_pos - NUM_CH;
         end
         w_idx = IW'(w_pos);
         if (req[w_idx]) begin
            valid = 1'b1;
            index = w_idx;
         end
      end
   end

endmodule

// File: rtl/handshake_arbiter.sv
// rtl/handshake_arbiter.sv - four-phase request/ack arbiter with round-robin grant
// Optional Ack-hold abort enabled by defining HS_TIMEOUT_EN.
module handshake_arbiter
   import handshake_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int NUM_CH         = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_CH-1:0]         DataRequest,
   input  logic [NUM_CH*WIDTH-1:0]   RegisterA,
   output logic [WIDTH-1:0]          Data,
   output logic [NUM_CH-1:0]         Ack,
   output logic [$clog2(NUM_CH)-1:0] GrantId,
   output logic                      Timeout
);

   localparam int IW = $clog2(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("handshake_arbiter: unsupported NUM_CH or TIMEOUT_CYCLES");
   end

   state_t              r_state;
   logic [NUM_CH-1:0]   r_ack;
   logic [WIDTH-1:0]    r_data;
   logic [IW-1:0]       r_grant_id;
   logic [IW-1:0]       r_ptr;

   logic                w_valid;
   logic [IW-1:0]       w_index;
   logic [WIDTH-1:0]    w_sel_data;
   logic [IW-1:0]       w_next_ptr;
   logic                w_req_held;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IW     (IW)
   ) u_rr (
      .req   (DataRequest),
      .ptr   (r_ptr),
      .valid (w_valid),
      .index (w_index)
   );

   assign w_sel_data = RegisterA[w_index*WIDTH +: WIDTH];
   assign w_req_held = DataRequest[r_grant_id];
   assign w_next_ptr = (r_grant_id == IW'(NUM_CH - 1)) ? '0 : r_grant_id + IW'(1);

`ifdef HS_TIMEOUT_EN
   localparam int CW = cnt_width(TIMEOUT_CYCLES);

   logic [CW-1:0] r_cnt;
   logic          r_timeout;
   logic          w_expire;

   assign w_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign Timeout  = r_timeout;
`else
   assign Timeout  = 1'b0;
`endif

   // Leaving ACK always passes through IDLE, which guarantees an Ack-low cycle between grants.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= IDLE;
         r_ack      <= '0;
         r_data     <= '0;
         r_grant_id <= '0;
         r_ptr      <= '0;
`ifdef HS_TIMEOUT_EN
         r_cnt      <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
`ifdef HS_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_state    <= ACK;
                  r_ack      <= NUM_CH'(1) << w_index;
                  r_data     <= w_sel_data;
                  r_grant_id <= w_index;
`ifdef HS_TIMEOUT_EN
                  r_cnt      <= '0;
`endif
               end
            end
            ACK: begin
               if (!w_req_held) begin
                  r_state <= IDLE;
                  r_ack   <= '0;
                  r_data  <= '0;
                  r_ptr   <= w_next_ptr;
               end
`ifdef HS_TIMEOUT_EN
               else if (w_expire) begin
                  r_state   <= IDLE;
                  r_ack     <= '0;
                  r_data    <= '0;
                  r_ptr     <= w_next_ptr;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Data    = r_data;
   assign Ack     = r_ack;
   assign GrantId = r_grant_id;

endmodule

// File: tb/tb_handshake_arbiter.sv
// tb/tb_handshake_arbiter.sv - scoreboard bench for handshake_arbiter (HS_TIMEOUT_EN aware)
module tb_handshake_arbiter;

   localparam int WIDTH  = 8;
   localparam int NUM_CH = 4;
   localparam int TOC    = 16;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [3:0]  DataRequest = '0;
   logic [31:0] RegisterA = '0;
   logic [7:0]  Data;
   logic [3:0]  Ack;
   logic [1:0]  GrantId;
   logic        Timeout;

   typedef struct {
      int id;
      int data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          to_pulses = 0;
   logic [3:0]  prev_ack = '0;
   int          ids[5] = '{0, 1, 2, 3, 0};

   handshake_arbiter #(
      .WIDTH          (WIDTH),
      .NUM_CH         (NUM_CH),
      .TIMEOUT_CYCLES (TOC)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .DataRequest (DataRequest),
      .RegisterA   (RegisterA),
      .Data        (Data),
      .Ack         (Ack),
      .GrantId     (GrantId),
      .Timeout     (Timeout)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input int id);
      exp_t e;
      e.id   = id;
      e.data = int'(RegisterA[id*8 +: 8]);
      sb.push_back(e);
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      Reset = 1'b1;
   endtask

   always @(negedge Clk) begin
      check_eq("ack_onehot0", 32'($onehot0(Ack)), 32'd1);
      if (prev_ack != 4'd0 && Ack != 4'd0)
         check_eq("ack_no_switch", 32'(Ack), 32'(prev_ack));
      if (Ack != 4'd0 && prev_ack == 4'd0) begin
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_grant", 32'(Ack), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("sb_ack", 32'(Ack), 32'(1 << mon_e.id));
            check_eq("sb_grant_id", 32'(GrantId), 32'(mon_e.id));
            check_eq("sb_data", 32'(Data), 32'(mon_e.data));
         end
      end
      if (Timeout) to_pulses++;
      prev_ack = Ack;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hi;
      int n;
      RegisterA = {8'h3C, 8'hA5, 8'h11, 8'h5A};
      #3;
      check_eq("rst_ack", 32'(Ack), 32'd0);
      check_eq("rst_data", 32'(Data), 32'd0);
      check_eq("rst_grant_id", 32'(GrantId), 32'd0);
      check_eq("rst_timeout", 32'(Timeout), 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;

      // single channel
      push(2);
      DataRequest = 4'b0100;
      tick();
      check_eq("single_ack", 32'(Ack), 32'h4);
      check_eq("single_data", 32'(Data), 32'hA5);
      check_eq("single_gid", 32'(GrantId), 32'd2);
      tick();
      check_eq("single_hold_ack", 32'(Ack), 32'h4);
      DataRequest = 4'b0000;
      tick();
      check_eq("single_rel_ack", 32'(Ack), 32'h0);
      check_eq("single_rel_data", 32'(Data), 32'h0);
      check_eq("single_rel_gid", 32'(GrantId), 32'd2);
      tick();

      // round robin from ptr 0
      do_reset();
      for (int g = 0; g < 5; g++) push(ids[g]);
      DataRequest = 4'hF;
      for (int g = 0; g < 5; g++) begin
         tick();
         check_eq("rr_grant", 32'(Ack), 32'(1 << ids[g]));
         repeat (2) tick();
         DataRequest[ids[g]] = 1'b0;
         tick();
         check_eq("rr_gap", 32'(Ack), 32'h0);
         DataRequest = (g == 4) ? 4'h0 : 4'hF;
      end
      tick();

      // data hold, then reset mid-ACK with ch3 pending
      do_reset();
      push(1);
      DataRequest = 4'b0010;
      tick();
      check_eq("hold_ack", 32'(Ack), 32'h2);
      RegisterA[15:8] = 8'h22;
      DataRequest[3]  = 1'b1;
      tick();
      tick();
      check_eq("hold_data", 32'(Data), 32'h11);
      check_eq("hold_ack2", 32'(Ack), 32'h2);
      Reset = 1'b0;
      DataRequest = 4'b1000;
      #2;
      check_eq("async_rst_ack", 32'(Ack), 32'h0);
      check_eq("async_rst_data", 32'(Data), 32'h0);
      check_eq("async_rst_gid", 32'(GrantId), 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      push(3);
      tick();
      check_eq("post_rst_ack", 32'(Ack), 32'h8);
      check_eq("post_rst_gid", 32'(GrantId), 32'd3);
      check_eq("post_rst_data", 32'(Data), 32'h3C);
      DataRequest = 4'b0000;
      tick();
      check_eq("post_rst_rel", 32'(Ack), 32'h0);

      // glitch request between edges
      tick();
      DataRequest[3] = 1'b1;
      #3;
      DataRequest[3] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("glitch_no_ack", 32'(Ack), 32'h0);
      end

`ifdef HS_TIMEOUT_EN
      do_reset();
      to_pulses = 0;
      push(0);
      push(1);
      DataRequest = 4'b0011;
      hi = 0;
      n  = 0;
      while (Ack != 4'h2 && n < 40) begin
         tick();
         if (Ack == 4'h1) hi++;
         n++;
      end
      check_eq("to_ack_cycles", 32'(hi), 32'(TOC));
      check_eq("to_pulses", 32'(to_pulses), 32'd1);
      check_eq("to_next_grant", 32'(Ack), 32'h2);
      DataRequest = 4'b0000;
      tick();
      tick();
`else
      do_reset();
      to_pulses = 0;
      push(0);
      DataRequest = 4'b0001;
      hi = 0;
      n  = 0;
      repeat (TOC + 8) begin
         tick();
         if (Ack == 4'h1) hi++;
         n++;
      end
      check_eq("no_to_hold_cycles", 32'(hi), 32'(n));
      check_eq("no_to_pulses", 32'(to_pulses), 32'd0);
      DataRequest = 4'b0000;
      tick();
      tick();
`endif

      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data bits per channel.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning the number of requesting channels (2..16).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum Ack-high cycles before abort (used only with HS_TIMEOUT_EN).
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port DataRequest, input, NUM_CH bits: per-channel level request.
REQ-007 SHALL have port RegisterA, input, NUM_CH*WIDTH bits: channel i source data at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port Data, output, WIDTH bits: registered data of the granted channel.
REQ-009 SHALL have port Ack, output, NUM_CH bits: one-hot or zero grant/acknowledge.
REQ-010 SHALL have port GrantId, output, clog2(NUM_CH) bits: index of the channel currently acknowledged.
REQ-011 SHALL have port Timeout, output, 1 bit: one-cycle abort pulse.

Function
REQ-012 SHALL run a four-phase handshake per channel: request rises, Ack rises, request falls, Ack falls.
REQ-013 SHALL implement states IDLE and ACK; all outputs SHALL be registered.
REQ-014 IDLE: with any DataRequest bit high at an edge, SHALL, at that edge, select one channel, set its Ack bit, load Data from its RegisterA slice, set GrantId, and go to ACK (1-cycle latency).
REQ-015 Selection SHALL be round-robin: search starts at pointer ptr and wraps NUM_CH-1 -> 0.
REQ-016 ACK: Data SHALL hold the value captured at grant; later RegisterA changes SHALL be ignored.
REQ-017 ACK: when DataRequest[GrantId] is low at an edge, SHALL clear Ack and Data to 0, set ptr = GrantId+1 (mod NUM_CH), and go to IDLE.
REQ-018 Ack SHALL stay low for at least one cycle between any two grants, including back-to-back grants to different channels.
REQ-019 Requests from non-granted channels during ACK SHALL wait, without loss, while held high.
REQ-020 A request that drops before being granted SHALL be ignored; no Ack results.
REQ-021 No more than one Ack bit SHALL ever be high.
REQ-022 In IDLE, Data SHALL be 0, Ack SHALL be 0, and GrantId SHALL hold its last value.

Reset
REQ-023 Reset low SHALL immediately force state IDLE, Ack=0, Data=0, GrantId=0, ptr=0, Timeout=0, and timeout counter=0, including mid-ACK.
REQ-024 After Reset deasserts, the first grant SHALL be possible at the first rising Clk edge.

Configuration
REQ-025 With macro HS_TIMEOUT_EN defined: a counter SHALL count Ack-high cycles; if the request is still high after TIMEOUT_CYCLES cycles in ACK, the block SHALL drop Ack, clear Data, pulse Timeout for 1 cycle, advance ptr past GrantId, and go to IDLE.
REQ-026 Without HS_TIMEOUT_EN: there SHALL be no counter, Timeout SHALL be tied 0, and ACK SHALL wait indefinitely.

Structure
REQ-027 Package handshake_pkg SHALL hold the state encoding (IDLE=0, ACK=1) and the counter-width constant derivation.
REQ-028 Round-robin selection SHALL be sub-module rr_arbiter (inputs: req, ptr; outputs: valid, index); it is purely combinational.

Verification
REQ-029 Single channel: NUM_CH=4, WIDTH=8, RegisterA[ch2]=0xA5, raise DataRequest[2] -> next edge Ack=0b0100, Data=0xA5, GrantId=2; drop request -> next edge Ack=0, Data=0.
REQ-030 Round-robin: all four requests held high and each released 3 cycles after its grant -> grant order 0,1,2,3,0, with one Ack-low cycle between grants.
REQ-031 Data hold: RegisterA[ch1] changes 0x11 -> 0x22 during ch1 ACK -> Data stays 0x11.
REQ-032 Reset mid-ACK: Reset low while Ack=0b0010 -> Ack, Data, and GrantId are 0 asynchronously; after release, the pending ch3 request is granted first from ptr=0.
REQ-033 Timeout (HS_TIMEOUT_EN, TIMEOUT_CYCLES=16): ch0 holds its request -> Ack drops after 16 Ack cycles, Timeout pulses once, and a waiting ch1 is granted next.
REQ-034 Glitch request: DataRequest[3] high for less than one clock between edges -> no Ack.
